// File: rtl/gfx_pkg.sv
// Shared graphics definitions: FSM state encoding, default raster geometry
// and coordinate/error widths used by the line, fill and blit engines.
package gfx_pkg;

  localparam int unsigned DEF_COORD_W       = 16;
  localparam int unsigned DEF_H_RES         = 640;
  localparam int unsigned DEF_V_RES         = 480;
  localparam int unsigned DEF_BYTES_PER_PIX = 2;

  // Bresenham coordinates and error term at the default coordinate width.
  typedef logic signed [DEF_COORD_W-1:0] coord_t;
  typedef logic signed [DEF_COORD_W+1:0] err_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_STEP  = 2'd2
  } state_t;

endpackage

// File: rtl/raster_addr_gen.sv
// Raster address generator.
// Purpose: flags whether (i_x,i_y) lies inside the visible raster
// (combinational) and registers its framebuffer byte address on i_load.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_load          capture the address of (i_x,i_y)
//   i_x, i_y        signed pixel coordinates
//   o_on_screen     0<=x<H_RES && 0<=y<V_RES
//   o_addr          BASE_ADDR + (y*H_RES + x)*BYTES_PER_PIX, registered
module raster_addr_gen
  import gfx_pkg::*;
#(
  parameter int unsigned        COORD_W       = DEF_COORD_W,
  parameter int unsigned        H_RES         = DEF_H_RES,
  parameter int unsigned        V_RES         = DEF_V_RES,
  parameter int unsigned        ADDR_W        = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR     = '0,
  parameter int unsigned        BYTES_PER_PIX = DEF_BYTES_PER_PIX
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_load,
  input  logic signed [COORD_W-1:0] i_x,
  input  logic signed [COORD_W-1:0] i_y,
  output logic                      o_on_screen,
  output logic [ADDR_W-1:0]         o_addr
);

  localparam logic [COORD_W:0] LP_H = (COORD_W+1)'(H_RES);
  localparam logic [COORD_W:0] LP_V = (COORD_W+1)'(V_RES);

  logic [ADDR_W-1:0] w_ux;
  logic [ADDR_W-1:0] w_uy;
  logic [ADDR_W-1:0] w_addr;

  // Sign bit rules out negatives; the remaining compare is then unsigned.
  always_comb begin
    o_on_screen = !i_x[COORD_W-1] && !i_y[COORD_W-1] &&
                  ({1'b0, i_x} < LP_H) && ({1'b0, i_y} < LP_V);
    w_ux   = ADDR_W'($unsigned(i_x));
    w_uy   = ADDR_W'($unsigned(i_y));
    w_addr = BASE_ADDR + (w_uy * ADDR_W'(H_RES) + w_ux) * ADDR_W'(BYTES_PER_PIX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_addr <= '0;
    end else if (i_load) begin
      o_addr <= w_addr;
    end
  end

endmodule

// File: rtl/line_raster_engine.sv
// Wireframe line rasteriser.
// Purpose: accepts a line command, walks it with all-octant integer
// Bresenham (endpoints inclusive) and emits one address/colour beat per
// on-screen pixel. Off-screen pixels are skipped one per cycle.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_x0/y0/x1/y1, cmd_color      signed endpoints and line colour
//   px_valid/px_ready               pixel stream handshake
//   px_addr, px_data                framebuffer byte address and colour
//   busy, done, px_count            status: busy span, done pulse, beats sent
module line_raster_engine
  import gfx_pkg::*;
#(
  parameter int unsigned        COORD_W       = DEF_COORD_W,
  parameter int unsigned        H_RES         = DEF_H_RES,
  parameter int unsigned        V_RES         = DEF_V_RES,
  parameter int unsigned        PIX_W         = 16,
  parameter int unsigned        ADDR_W        = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR     = '0,
  parameter int unsigned        BYTES_PER_PIX = DEF_BYTES_PER_PIX,
  parameter int unsigned        CNT_W         = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [COORD_W-1:0] cmd_x0,
  input  logic signed [COORD_W-1:0] cmd_y0,
  input  logic signed [COORD_W-1:0] cmd_x1,
  input  logic signed [COORD_W-1:0] cmd_y1,
  input  logic [PIX_W-1:0]          cmd_color,
  output logic                      px_valid,
  input  logic                      px_ready,
  output logic [ADDR_W-1:0]         px_addr,
  output logic [PIX_W-1:0]          px_data,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          px_count
);

  localparam int unsigned EW = COORD_W + 2;

  state_t                    r_state;
  logic signed [COORD_W-1:0] r_x, r_y, r_x1, r_y1;
  logic signed [EW-1:0]      r_dx, r_dy, r_err;
  logic                      r_sx_neg, r_sy_neg;
  logic                      r_cmd_ready, r_px_valid, r_busy, r_done;
  logic [PIX_W-1:0]          r_color;
  logic [CNT_W-1:0]          r_count;

  logic signed [COORD_W:0]   w_ddx, w_ddy, w_adx, w_ady;
  logic signed [EW-1:0]      w_dx_init, w_dy_init, w_nerr;
  logic signed [EW:0]        w_e2;
  logic                      w_stepx, w_stepy, w_last, w_adv, w_load, w_on;
  logic signed [COORD_W-1:0] w_nx, w_ny, w_ax, w_ay;

  always_comb begin
    // Setup terms; r_x/r_y still hold the start point while in SETUP.
    w_ddx     = {r_x1[COORD_W-1], r_x1} - {r_x[COORD_W-1], r_x};
    w_ddy     = {r_y1[COORD_W-1], r_y1} - {r_y[COORD_W-1], r_y};
    w_adx     = w_ddx[COORD_W] ? -w_ddx : w_ddx;
    w_ady     = w_ddy[COORD_W] ? -w_ddy : w_ddy;
    w_dx_init = $signed({1'b0, w_adx});
    w_dy_init = -$signed({1'b0, w_ady});

    // Both decisions use e2 from the old error, so x and y may step together.
    w_e2    = {r_err, 1'b0};
    w_stepx = w_e2 >= $signed({r_dy[EW-1], r_dy});
    w_stepy = w_e2 <= $signed({r_dx[EW-1], r_dx});
    w_nerr  = r_err + (w_stepx ? r_dy : '0) + (w_stepy ? r_dx : '0);
    w_nx    = w_stepx ? (r_sx_neg ? r_x - COORD_W'(1) : r_x + COORD_W'(1)) : r_x;
    w_ny    = w_stepy ? (r_sy_neg ? r_y - COORD_W'(1) : r_y + COORD_W'(1)) : r_y;

    w_last  = (r_x == r_x1) && (r_y == r_y1);
    // A clipped pixel has px_valid low and so advances without a handshake.
    w_adv   = (r_state == S_STEP) && (!r_px_valid || px_ready);
    // Address of the pixel about to be presented: the start point in SETUP,
    // the successor of the current pixel on a STEP advance.
    w_ax    = (r_state == S_STEP) ? w_nx : r_x;
    w_ay    = (r_state == S_STEP) ? w_ny : r_y;
    w_load  = (r_state == S_SETUP) || (w_adv && !w_last);
  end

  raster_addr_gen #(
    .COORD_W       (COORD_W),
    .H_RES         (H_RES),
    .V_RES         (V_RES),
    .ADDR_W        (ADDR_W),
    .BASE_ADDR     (BASE_ADDR),
    .BYTES_PER_PIX (BYTES_PER_PIX)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_x         (w_ax),
    .i_y         (w_ay),
    .o_on_screen (w_on),
    .o_addr      (px_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
      r_sx_neg    <= 1'b0;
      r_sy_neg    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_px_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_color     <= '0;
      r_count     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_x         <= cmd_x0;
            r_y         <= cmd_y0;
            r_x1        <= cmd_x1;
            r_y1        <= cmd_y1;
            r_color     <= cmd_color;
            r_count     <= '0;
            r_busy      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= S_SETUP;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        S_SETUP: begin
          r_dx       <= w_dx_init;
          r_dy       <= w_dy_init;
          r_err      <= w_dx_init + w_dy_init;
          r_sx_neg   <= !(r_x < r_x1);
          r_sy_neg   <= !(r_y < r_y1);
          r_px_valid <= w_on;
          r_state    <= S_STEP;
        end
        S_STEP: begin
          if (w_adv) begin
            if (r_px_valid && (r_count != '1)) begin
              r_count <= r_count + CNT_W'(1);
            end
            if (w_last) begin
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_px_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_x        <= w_nx;
              r_y        <= w_ny;
              r_err      <= w_nerr;
              r_px_valid <= w_on;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign px_valid  = r_px_valid;
  assign px_data   = r_color;
  assign busy      = r_busy;
  assign done      = r_done;
  assign px_count  = r_count;

endmodule
